// File: rtl/mem_sub_word_lsu.sv
// Load/store initiator in front of a word-only memory: adds byte/halfword loads
// (with sign/zero extension) and byte/halfword stores via read-modify-write.
module mem_sub_word_lsu #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        mod,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRd, StMerge, StWr, StLdcap, StErr} state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic [1:0]          mod_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdata_q;
    logic [31:0]         merge_q;
    logic [31:0]         rdata_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                misaligned;
    logic [31:0]         merged;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_val;

    always_comb begin
        accept     = req && (state_q == StIdle);
        misaligned = ((mod == 2'b00) && (addr[1:0] != 2'b00)) ||
                     ((mod == 2'b01) && addr[0]);

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (misaligned)          state_d = StErr;
                    else if (!we)            state_d = StRd;
                    else if (mod == 2'b00)   state_d = StWr;
                    else                     state_d = StRd;
                end
            end
            StRd:    state_d = we_q ? StMerge : StLdcap;
            StMerge: state_d = StWr;
            StWr:    state_d = StIdle;
            StLdcap: state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane replacement for RMW; all other bytes pass through untouched.
    always_comb begin
        merged = mem_rdata;
        if (mod_q[1]) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        if (mod_q == 2'b00)  load_val = mem_rdata;
        else if (mod_q[1])   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
        else                 load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            mod_q   <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StWr) || (state_q == StLdcap) || (accept && misaligned);
            err_q   <= accept && misaligned;
            if (accept) begin
                we_q    <= we;
                mod_q   <= mod;
                uns_q   <= uns;
                addr_q  <= addr;
                wdata_q <= wdata[15:0];
                merge_q <= wdata;
            end
            if (state_q == StMerge) merge_q <= merged;
            if (state_q == StLdcap) rdata_q <= load_val;
        end
    end

    assign ready     = (state_q == StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_w_en  = (state_q == StWr);
    assign mem_addr  = addr_q;
    assign mem_wdata = merge_q;

endmodule
